// File: rtl/cuckoo_lookup.sv
// cuckoo_lookup: read-side probe engine for the two-table cuckoo hash store.
// Optional delete-on-hit is compiled in when CUCKOO_DELETE_EN is defined.
//
//  state | meaning
//  IDLE  | ready, waiting for a lookup request
//  RD1   | read enable to table 1 at idx1
//  CMP1  | compare table 1 read data against key
//  RD2   | read enable to table 2 at idx2
//  CMP2  | compare table 2 read data against key
//  DEL   | one-cycle clear pulse to the hit table (CUCKOO_DELETE_EN only)
//  RESP  | response held until rsp_ready
module cuckoo_lookup #(
    parameter int DEPTH = 20,
    parameter int KEY_W = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KEY_W-1:0] req_key,
    input  logic [IDX_W-1:0] req_idx1,
    input  logic [IDX_W-1:0] req_idx2,
    input  logic             req_del,
    output logic             t1_ren,
    output logic             t2_ren,
    output logic [IDX_W-1:0] t1_raddr,
    output logic [IDX_W-1:0] t2_raddr,
    input  logic [KEY_W-1:0] t1_rdata,
    input  logic [KEY_W-1:0] t2_rdata,
    input  logic             t1_rfilled,
    input  logic             t2_rfilled,
`ifdef CUCKOO_DELETE_EN
    output logic             t1_clr,
    output logic             t2_clr,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic             rsp_table,
    output logic [IDX_W-1:0] rsp_index
);

`ifdef CUCKOO_DELETE_EN
    typedef enum logic [2:0] {IDLE, RD1, CMP1, RD2, CMP2, RESP, DEL} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD1, CMP1, RD2, CMP2, RESP} state_t;
`endif

    // One extra bit so DEPTH == 2**IDX_W still compares correctly.
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

    state_t           state_q, state_d, hit_next;
    logic [KEY_W-1:0] key_q;
    logic [IDX_W-1:0] idx1_q, idx2_q;
    logic             del_q;
    logic             req_in1, req_in2, q_in2;
    logic             hit1, hit2;

    assign req_in1 = {1'b0, req_idx1} < DEPTH_L;
    assign req_in2 = {1'b0, req_idx2} < DEPTH_L;
    assign q_in2   = {1'b0, idx2_q} < DEPTH_L;
    assign hit1    = t1_rfilled && (t1_rdata == key_q);
    assign hit2    = t2_rfilled && (t2_rdata == key_q);

    // Addresses follow the latched indices, so during DEL they already sit at the hit slot.
    assign t1_raddr = idx1_q;
    assign t2_raddr = idx2_q;

`ifdef CUCKOO_DELETE_EN
    logic del_unused;
    assign del_unused = 1'b0;
`else
    logic del_unused;
    assign del_unused = req_del;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        t1_ren    = 1'b0;
        t2_ren    = 1'b0;
        rsp_valid = 1'b0;
`ifdef CUCKOO_DELETE_EN
        t1_clr    = 1'b0;
        t2_clr    = 1'b0;
        hit_next  = del_q ? DEL : RESP;
`else
        hit_next  = RESP;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_in1)      state_d = RD1;
                    else if (req_in2) state_d = RD2;
                    else              state_d = RESP;
                end
            end
            RD1: begin
                t1_ren  = 1'b1;
                state_d = CMP1;
            end
            CMP1: begin
                if (hit1)       state_d = hit_next;
                else if (q_in2) state_d = RD2;
                else            state_d = RESP;
            end
            RD2: begin
                t2_ren  = 1'b1;
                state_d = CMP2;
            end
            CMP2: begin
                state_d = hit2 ? hit_next : RESP;
            end
`ifdef CUCKOO_DELETE_EN
            DEL: begin
                t1_clr  = ~rsp_table;
                t2_clr  = rsp_table;
                state_d = RESP;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q     <= '0;
            idx1_q    <= '0;
            idx2_q    <= '0;
            del_q     <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_table <= 1'b0;
            rsp_index <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        key_q     <= req_key;
                        idx1_q    <= req_idx1;
                        idx2_q    <= req_idx2;
`ifdef CUCKOO_DELETE_EN
                        del_q     <= req_del;
`else
                        del_q     <= 1'b0;
`endif
                        rsp_hit   <= 1'b0;
                        rsp_table <= 1'b0;
                        rsp_index <= '0;
                    end
                end
                CMP1: begin
                    if (hit1) begin
                        rsp_hit   <= 1'b1;
                        rsp_table <= 1'b0;
                        rsp_index <= idx1_q;
                    end
                end
                CMP2: begin
                    if (hit2) begin
                        rsp_hit   <= 1'b1;
                        rsp_table <= 1'b1;
                        rsp_index <= idx2_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cuckoo_lookup.sv
// Self-checking bench for cuckoo_lookup; bench owns the table storage and a
// spec-level reference model. Delete scenarios compile with CUCKOO_DELETE_EN.
module tb_cuckoo_lookup;
    localparam int DEPTH = 20;
    localparam int KEY_W = 32;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [KEY_W-1:0] req_key = '0;
    logic [IDX_W-1:0] req_idx1 = '0;
    logic [IDX_W-1:0] req_idx2 = '0;
    logic             req_del = 1'b0;
    logic             t1_ren, t2_ren;
    logic [IDX_W-1:0] t1_raddr, t2_raddr;
    logic [KEY_W-1:0] t1_rdata = '0;
    logic [KEY_W-1:0] t2_rdata = '0;
    logic             t1_rfilled = 1'b0;
    logic             t2_rfilled = 1'b0;
    logic             t1_clr, t2_clr;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_hit, rsp_table;
    logic [IDX_W-1:0] rsp_index;

    logic [KEY_W-1:0] m1 [0:31];
    logic [KEY_W-1:0] m2 [0:31];
    logic             f1 [0:31];
    logic             f2 [0:31];

    int n_ren1 = 0, n_ren2 = 0, n_clr1 = 0, n_clr2 = 0;
    logic [IDX_W-1:0] a_ren1 = '0, a_ren2 = '0, a_clr1 = '0, a_clr2 = '0;

    int total = 0;
    int bad = 0;

    cuckoo_lookup #(.DEPTH(DEPTH), .KEY_W(KEY_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .req_idx1(req_idx1), .req_idx2(req_idx2), .req_del(req_del),
        .t1_ren(t1_ren), .t2_ren(t2_ren), .t1_raddr(t1_raddr), .t2_raddr(t2_raddr),
        .t1_rdata(t1_rdata), .t2_rdata(t2_rdata),
        .t1_rfilled(t1_rfilled), .t2_rfilled(t2_rfilled),
`ifdef CUCKOO_DELETE_EN
        .t1_clr(t1_clr), .t2_clr(t2_clr),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_table(rsp_table), .rsp_index(rsp_index)
    );

`ifndef CUCKOO_DELETE_EN
    assign t1_clr = 1'b0;
    assign t2_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    // Synchronous-read table model; data is scrambled on cycles without an enable
    // so a sample taken at the wrong cycle cannot match.
    always @(posedge clk) begin
        if (t1_ren) begin
            t1_rdata   <= m1[t1_raddr];
            t1_rfilled <= f1[t1_raddr];
            n_ren1     <= n_ren1 + 1;
            a_ren1     <= t1_raddr;
        end else begin
            t1_rdata   <= $urandom;
            t1_rfilled <= 1'($urandom_range(0, 1));
        end
        if (t2_ren) begin
            t2_rdata   <= m2[t2_raddr];
            t2_rfilled <= f2[t2_raddr];
            n_ren2     <= n_ren2 + 1;
            a_ren2     <= t2_raddr;
        end else begin
            t2_rdata   <= $urandom;
            t2_rfilled <= 1'($urandom_range(0, 1));
        end
        if (t1_clr) begin
            n_clr1 <= n_clr1 + 1;
            a_clr1 <= t1_raddr;
        end
        if (t2_clr) begin
            n_clr2 <= n_clr2 + 1;
            a_clr2 <= t2_raddr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_tables();
        for (int i = 0; i < 32; i++) begin
            m1[i] = '0; m2[i] = '0; f1[i] = 1'b0; f2[i] = 1'b0;
        end
    endtask

    task automatic lookup(input logic [KEY_W-1:0] key, input logic [IDX_W-1:0] i1,
                          input logic [IDX_W-1:0] i2, input logic del, input int rdly);
        bit in1, in2, h1, h2, edel;
        logic [IDX_W+1:0] exp_rsp;
        int elat, er1, er2, lat, b_r1, b_r2, b_c1, b_c2;
        in1  = (int'(i1) < DEPTH);
        in2  = (int'(i2) < DEPTH);
        h1   = in1 && f1[i1] && (m1[i1] == key);
        h2   = !h1 && in2 && f2[i2] && (m2[i2] == key);
        exp_rsp = h1 ? {1'b1, 1'b0, i1} : h2 ? {1'b1, 1'b1, i2} : '0;
        er1  = in1 ? 1 : 0;
        er2  = (!h1 && in2) ? 1 : 0;
        edel = 1'b0;
`ifdef CUCKOO_DELETE_EN
        edel = del && (h1 || h2);
`endif
        elat = 1 + 2 * er1 + 2 * er2 + (edel ? 1 : 0);
        b_r1 = n_ren1; b_r2 = n_ren2; b_c1 = n_clr1; b_c2 = n_clr2;

        @(negedge clk);
        req_valid = 1'b1; req_key = key; req_idx1 = i1; req_idx2 = i2; req_del = del;
        rsp_ready = 1'b0;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_key = $urandom;
        req_idx1 = IDX_W'($urandom); req_idx2 = IDX_W'($urandom); req_del = 1'($urandom);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 30) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (lat !== elat) begin
            bad++; $display("FAIL latency key=%0d: got %0d want %0d", key, lat, elat);
        end
        total++;
        if ({rsp_hit, rsp_table, rsp_index} !== exp_rsp) begin
            bad++; $display("FAIL rsp key=%0d: got hit=%b tbl=%b idx=%0d want %b", key,
                            rsp_hit, rsp_table, rsp_index, exp_rsp);
        end
        for (int d = 0; d < rdly; d++) begin
            @(posedge clk); #1;
            total++;
            if ({rsp_valid, rsp_hit, rsp_table, rsp_index} !== {1'b1, exp_rsp}) begin
                bad++; $display("FAIL rsp_hold cycle %0d: got v=%b %b%b%0d want %b", d,
                                rsp_valid, rsp_hit, rsp_table, rsp_index, exp_rsp);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++; $display("FAIL rsp_done: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
        total++;
        if ((n_ren1 - b_r1) !== er1 || (n_ren2 - b_r2) !== er2) begin
            bad++; $display("FAIL ren_count: got %0d/%0d want %0d/%0d",
                            n_ren1 - b_r1, n_ren2 - b_r2, er1, er2);
        end
        if (er1 == 1) begin
            total++;
            if (a_ren1 !== i1) begin
                bad++; $display("FAIL t1_raddr: got %0d want %0d", a_ren1, i1);
            end
        end
        if (er2 == 1) begin
            total++;
            if (a_ren2 !== i2) begin
                bad++; $display("FAIL t2_raddr: got %0d want %0d", a_ren2, i2);
            end
        end
        total++;
        if ((n_clr1 - b_c1) !== ((edel && h1) ? 1 : 0) ||
            (n_clr2 - b_c2) !== ((edel && h2) ? 1 : 0)) begin
            bad++; $display("FAIL clr_count: got %0d/%0d want %0d/%0d", n_clr1 - b_c1,
                            n_clr2 - b_c2, (edel && h1) ? 1 : 0, (edel && h2) ? 1 : 0);
        end
        if (edel) begin
            total++;
            if ((h1 ? a_clr1 : a_clr2) !== (h1 ? i1 : i2)) begin
                bad++; $display("FAIL clr_addr: got %0d want %0d", h1 ? a_clr1 : a_clr2,
                                h1 ? i1 : i2);
            end
            if (h1) f1[i1] = 1'b0;
            else    f2[i2] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_hit, rsp_table, rsp_index, t1_ren, t2_ren,
             t1_clr, t2_clr, t1_raddr, t2_raddr} !== {2'b10, 1'b0, 1'b0, 5'd0, 4'b0, 10'd0}) begin
            bad++; $display("FAIL reset_values: got rdy=%b v=%b hit=%b tbl=%b idx=%0d ren=%b%b clr=%b%b a=%0d/%0d",
                            req_ready, rsp_valid, rsp_hit, rsp_table, rsp_index, t1_ren, t2_ren,
                            t1_clr, t2_clr, t1_raddr, t2_raddr);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        clear_tables();
        m1[0] = 70; f1[0] = 1'b1;
        lookup(70, 0, 10, 1'b0, 0);
        m2[2] = 82; f2[2] = 1'b1; f1[8] = 1'b0; m1[8] = 82;
        lookup(82, 8, 2, 1'b0, 0);
        m1[11] = 11; f1[11] = 1'b0; m2[19] = 5; f2[19] = 1'b1;
        lookup(11, 11, 19, 1'b0, 3);
        lookup(11, 25, 31, 1'b0, 0);
        m1[4] = 77; f1[4] = 1'b1; m2[4] = 77; f2[4] = 1'b1;
        lookup(77, 4, 4, 1'b0, 1);
        m2[9] = 91; f2[9] = 1'b1;
        lookup(91, 29, 9, 1'b0, 0);
        lookup(91, 9, 20, 1'b0, 0);
    endtask

    task automatic test_delete();
`ifdef CUCKOO_DELETE_EN
        m2[5] = 13; f2[5] = 1'b1; f1[17] = 1'b0;
        lookup(13, 17, 5, 1'b1, 0);
        lookup(13, 17, 5, 1'b1, 0);
        m1[6] = 66; f1[6] = 1'b1;
        lookup(66, 6, 1, 1'b1, 2);
`else
        m2[5] = 13; f2[5] = 1'b1;
        lookup(13, 17, 5, 1'b1, 0);
        lookup(13, 17, 5, 1'b1, 0);
`endif
    endtask

    task automatic test_reset_mid_lookup();
        int b_c1, b_c2;
        m1[3] = 44; f1[3] = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_key = 44; req_idx1 = 3; req_idx2 = 7; req_del = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_del = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        b_c1 = n_clr1; b_c2 = n_clr2;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL mid_reset: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        total++;
        if ((n_clr1 - b_c1) !== 0 || (n_clr2 - b_c2) !== 0) begin
            bad++; $display("FAIL mid_reset_clr: got %0d/%0d pulses want 0/0",
                            n_clr1 - b_c1, n_clr2 - b_c2);
        end
        lookup(44, 3, 7, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        m1[12] = 120; f1[12] = 1'b1;
        m1[13] = 130; f1[13] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lookup((i % 2 == 0) ? 120 : 130, (i % 2 == 0) ? 12 : 13, 14, 1'b0, 0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 32; i++) begin
            m1[i] = 100 + $urandom_range(0, 7); f1[i] = 1'($urandom_range(0, 1));
            m2[i] = 100 + $urandom_range(0, 7); f2[i] = 1'($urandom_range(0, 1));
        end
        for (int n = 0; n < 40; n++) begin
            lookup(100 + $urandom_range(0, 7), IDX_W'($urandom_range(0, 31)),
                   IDX_W'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 2));
        end
    endtask

    initial begin
        clear_tables();
        test_reset();
        test_directed();
        test_delete();
        test_reset_mid_lookup();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
